io_sw_debounce: RTL and testbench

- Upstream input-conditioning stage for the single-cycle processor's switch input port.
- Takes the raw, asynchronous, bouncing board switches and synchronises them into clk_i.
- Debounces each bit and drives the clean 32-bit word consumed as io_sw_i by the processor top.
- Also provides per-bit change pulses and a settled flag for bench checking and optional interrupt use.

---
 rtl/io_pkg.sv | 17 +
 rtl/sw_debounce_bit.sv | 65 ++++++
 rtl/io_sw_debounce.sv | 76 +++++++
 tb/tb_io_sw_debounce.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared constants and types for the switch input port.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int IO_WIDTH        = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TICK_DIV    = 50000;   // 1 ms sample tick at 50 MHz
    localparam int DEF_STABLE_CNT  = 4;

    typedef logic [IO_WIDTH-1:0] io_word_t;

endpackage : io_pkg
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_bit
//  Description : One switch bit: synchroniser chain, tick-driven stability
//                counter, debounced output and one-cycle change pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_bit
    import io_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic sw_o,
    output logic change_o
);

    localparam int               CNT_W    = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   differs;
    logic [CNT_W-1:0]       cnt;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign differs = synced ^ sw_o;

    // Plain flop chain bringing the asynchronous pin into the clock domain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Count consecutive ticks that disagree with the output; flip after STABLE_CNT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            sw_o     <= 1'b0;
            change_o <= 1'b0;
        end else begin
            change_o <= 1'b0;
            if (tick_i) begin
                if (!differs) begin
                    cnt <= '0;                  // any agreeing sample restarts the window
                end else if (cnt == CNT_LAST) begin
                    sw_o     <= synced;
                    cnt      <= '0;
                    change_o <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule : sw_debounce_bit
`default_nettype wire

// File: rtl/io_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : io_sw_debounce
//  Description : Synchronises and debounces the board switches into the
//                clean word feeding the processor io_sw_i port; also gives
//                per-bit change pulses and a sticky settled flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_sw_debounce
    import io_pkg::*;
#(
    parameter int WIDTH       = IO_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] io_sw_o,
    output logic [WIDTH-1:0] sw_change_o,
    output logic             sw_valid_o
);

    // A one-cycle divider still needs a one-bit counter that simply sits at 0
    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam int               VAL_W    = $clog2(STABLE_CNT + 1);
    localparam logic [VAL_W-1:0] VAL_LAST = VAL_W'(STABLE_CNT - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [VAL_W-1:0] val_cnt;

    assign tick = (pre_cnt == PRE_LAST);

    // Free-running sample prescaler, wraps silently
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Settled flag: set on the STABLE_CNT-th tick after reset, then frozen
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_cnt    <= '0;
            sw_valid_o <= 1'b0;
        end else if (tick && !sw_valid_o) begin
            val_cnt <= val_cnt + VAL_W'(1);
            if (val_cnt == VAL_LAST) begin
                sw_valid_o <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .tick_i   (tick),
            .raw_i    (sw_raw_i[i]),
            .sw_o     (io_sw_o[i]),
            .change_o (sw_change_o[i])
        );
    end

endmodule : io_sw_debounce
`default_nettype wire

// File: tb/tb_io_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_sw_debounce
//  Description : Self-checking bench for io_sw_debounce. Instance 0 uses
//                TICK_DIV=4/STABLE_CNT=3, instance 1 the degenerate 1/1 case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_sw_debounce;

    localparam int SS  = 2;
    localparam int TD0 = 4;
    localparam int SC0 = 3;
    localparam int TD1 = 1;
    localparam int SC1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raw0, raw1;
    logic [31:0] io0, chg0, io1, chg1;
    logic        val0, val1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_sw_debounce #(.WIDTH(32), .SYNC_STAGES(SS), .TICK_DIV(TD0), .STABLE_CNT(SC0)) dut0 (
        .clk_i(clk), .rst_i(rst), .sw_raw_i(raw0),
        .io_sw_o(io0), .sw_change_o(chg0), .sw_valid_o(val0)
    );

    io_sw_debounce #(.WIDTH(32), .SYNC_STAGES(SS), .TICK_DIV(TD1), .STABLE_CNT(SC1)) dut1 (
        .clk_i(clk), .rst_i(rst), .sw_raw_i(raw1),
        .io_sw_o(io1), .sw_change_o(chg1), .sw_valid_o(val1)
    );

    // ---------------- reference model ----------------
    // Per instance: raw samples delayed SS clocks, tick from cycle index since
    // reset, and a count of consecutive ticks that disagree with the output.
    logic [31:0] hist   [2][SS];
    int          streak [2][32];
    logic [31:0] m_out  [2];
    logic [31:0] m_chg  [2];
    logic        m_val  [2];
    int          m_cyc  [2];
    int          m_ticks[2];

    function automatic int tdiv(input int k);
        return (k == 0) ? TD0 : TD1;
    endfunction

    function automatic int scnt(input int k);
        return (k == 0) ? SC0 : SC1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < SS; s++) hist[k][s] = '0;
            for (int b = 0; b < 32; b++) streak[k][b] = 0;
            m_out[k] = '0; m_chg[k] = '0; m_val[k] = 1'b0;
            m_cyc[k] = 0;  m_ticks[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [31:0] raw);
        logic [31:0] seen;
        bit          tick;
        seen = hist[k][SS-1];
        for (int s = SS - 1; s > 0; s--) hist[k][s] = hist[k][s-1];
        hist[k][0] = raw;
        tick = ((m_cyc[k] % tdiv(k)) == tdiv(k) - 1);
        m_cyc[k]++;
        m_chg[k] = '0;
        if (tick) begin
            m_ticks[k]++;
            if (m_ticks[k] >= scnt(k)) m_val[k] = 1'b1;
            for (int b = 0; b < 32; b++) begin
                if (seen[b] != m_out[k][b]) begin
                    streak[k][b]++;
                    if (streak[k][b] == scnt(k)) begin
                        m_out[k][b] = seen[b];
                        m_chg[k][b] = 1'b1;
                        streak[k][b] = 0;
                    end
                end else begin
                    streak[k][b] = 0;
                end
            end
        end
    endtask

    // Model advances on the same edges as the design, with async clear
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0, raw0);
            model_step(1, raw1);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output against the model
    task automatic cyc();
        @(negedge clk);
        chk("io0",  io0,       m_out[0]);
        chk("chg0", chg0,      m_chg[0]);
        chk("val0", 32'(val0), 32'(m_val[0]));
        chk("io1",  io1,       m_out[1]);
        chk("chg1", chg1,      m_chg[1]);
        chk("val1", 32'(val1), 32'(m_val[1]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat, lat_v0, lat_v1, pulses;
        bit          found, flipped;
        logic [31:0] cap_io, cap_chg, v;

        // 1. reset held with all switches high
        rst  = 1'b1;
        raw0 = '1;
        raw1 = '1;
        repeat (3) cyc();
        chk("reset_io0",  io0,       32'h0);
        chk("reset_chg0", chg0,      32'h0);
        chk("reset_val0", 32'(val0), 32'h0);
        chk("reset_io1",  io1,       32'h0);
        raw0 = '0;
        raw1 = '0;
        #2 rst = 1'b0;
        repeat (5) cyc();

        // 2. clean step on bit 0
        raw0[0] = 1'b1;
        found = 0; lat = 0; cap_chg = '0; cap_io = '0;
        for (int k = 1; k <= 20 && !found; k++) begin
            cyc();
            if (io0[0]) begin found = 1; lat = k; cap_chg = chg0; cap_io = io0; end
        end
        chk("step_latency_11_14", 32'(found && lat >= 11 && lat <= 14), 32'h1);
        chk("step_change",        cap_chg, 32'h1);
        chk("step_word",          cap_io,  32'h1);
        cyc();
        chk("step_change_clear",  chg0,    32'h0);

        // 3. bounce bit 5 every 3 cycles, then hold high
        pulses = 0; flipped = 0;
        for (int t = 0; t < 40; t++) begin
            if (t % 3 == 0) raw0[5] = ~raw0[5];
            cyc();
            if (chg0[5]) pulses++;
            if (io0[5])  flipped = 1;
        end
        chk("bounce_no_pulse", 32'(pulses),  32'h0);
        chk("bounce_no_flip",  32'(flipped), 32'h0);
        raw0[5] = 1'b1;
        found = 0; lat = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            cyc();
            if (io0[5]) begin found = 1; lat = k; end
        end
        chk("bounce_settle_le_14", 32'(found && lat <= 14), 32'h1);

        // 4. simultaneous step of many bits
        raw0 = '0;
        for (int k = 0; k < 30 && io0 != 32'h0; k++) cyc();
        chk("simul_cleared", io0, 32'h0);
        raw0 = 32'hA5A5_A5A5;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (chg0 != 32'h0) begin found = 1; cap_chg = chg0; cap_io = io0; end
        end
        chk("simul_change", cap_chg, 32'hA5A5_A5A5);
        chk("simul_word",   cap_io,  32'hA5A5_A5A5);
        cyc();
        chk("simul_change_clear", chg0, 32'h0);

        // random traffic on both instances, checked every cycle by the model
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 5) == 0) raw0 ^= ($urandom & $urandom);
            if ($urandom_range(0, 2) == 0) raw1 ^= ($urandom & $urandom & $urandom);
            cyc();
        end

        // 5. reset while bit 3 is part-way through its window
        raw0 = 32'hA5A5_A5A5;
        for (int k = 0; k < 40 && io0 != 32'hA5A5_A5A5; k++) cyc();
        chk("mid_baseline", io0, 32'hA5A5_A5A5);
        raw0[3] = 1'b1;
        for (int k = 0; k < 20 && streak[0][3] < 2; k++) cyc();
        chk("mid_not_flipped", 32'(io0[3]), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_io0",  io0,       32'h0);
        chk("async_chg0", chg0,      32'h0);
        chk("async_val0", 32'(val0), 32'h0);
        chk("async_io1",  io1,       32'h0);
        chk("async_val1", 32'(val1), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        lat = 0; lat_v0 = 0; lat_v1 = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (io0[3] && lat == 0) begin lat = k; cap_io = io0; cap_chg = chg0; end
            if (val0 && lat_v0 == 0) lat_v0 = k;
            if (val1 && lat_v1 == 0) lat_v1 = k;
        end
        chk("restart_latency",  32'(lat),    32'd12);
        chk("restart_word",     cap_io,      32'hA5A5_A5AD);
        chk("restart_change",   cap_chg,     32'hA5A5_A5AD);
        chk("valid_rise_tick3", 32'(lat_v0), 32'd12);
        chk("valid_rise_deg",   32'(lat_v1), 32'd1);

        // 6. degenerate instance follows a step after SYNC_STAGES+1 edges
        raw1 = '0;
        repeat (5) cyc();
        v    = $urandom | 32'h1;
        raw1 = v;
        cyc();
        chk("deg_edge1_hold", io1, 32'h0);
        cyc();
        chk("deg_edge2_hold", io1, 32'h0);
        cyc();
        chk("deg_edge3_word",   io1,  v);
        chk("deg_edge3_change", chg1, v);
        cyc();
        chk("deg_change_clear", chg1, 32'h0);
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_io_sw_debounce
`default_nettype wire
